// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM state type, exception
// vector bit positions and the matching mcause exception codes.
package trap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect,
        StRet
    } trap_state_e;

    // Bit positions inside except_signal
    localparam int unsigned BIT_LD_MISALIGN = 0;
    localparam int unsigned BIT_LD_ACCESS   = 1;
    localparam int unsigned BIT_ST_MISALIGN = 2;
    localparam int unsigned BIT_ST_ACCESS   = 3;
    localparam int unsigned BIT_LD_PAGE     = 4;
    localparam int unsigned BIT_ST_PAGE     = 5;
    localparam int unsigned BIT_BREAKPOINT  = 6;

    // Exception codes written to mcause (interrupt bit always 0)
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;
    localparam logic [3:0] CAUSE_LD_PAGE     = 4'd13;
    localparam logic [3:0] CAUSE_ST_PAGE     = 4'd15;
    localparam logic [3:0] CAUSE_BREAKPOINT  = 4'd3;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder for the E-stage exception vector.
// Ports:
//   vec    - 7-bit exception vector
//   any    - at least one exception bit set
//   cause  - exception code of the highest-priority set bit (0 if none)
//   use_pc - trap value is the PC (breakpoint) rather than the data address
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [6:0] vec,
    output logic       any,
    output logic [3:0] cause,
    output logic       use_pc
);

    assign any = |vec;

    // Order: breakpoint, store misaligned, load misaligned, store page fault,
    // load page fault, store access fault, load access fault.
    always_comb begin
        cause  = 4'd0;
        use_pc = 1'b0;
        if (vec[BIT_BREAKPOINT]) begin
            cause  = CAUSE_BREAKPOINT;
            use_pc = 1'b1;
        end else if (vec[BIT_ST_MISALIGN]) begin
            cause = CAUSE_ST_MISALIGN;
        end else if (vec[BIT_LD_MISALIGN]) begin
            cause = CAUSE_LD_MISALIGN;
        end else if (vec[BIT_ST_PAGE]) begin
            cause = CAUSE_ST_PAGE;
        end else if (vec[BIT_LD_PAGE]) begin
            cause = CAUSE_LD_PAGE;
        end else if (vec[BIT_ST_ACCESS]) begin
            cause = CAUSE_ST_ACCESS;
        end else if (vec[BIT_LD_ACCESS]) begin
            cause = CAUSE_LD_ACCESS;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: captures mepc/mcause/mtval for the highest-priority
// E-stage exception, flushes the pipeline for FLUSH_CYCLES cycles and then
// redirects fetch to mtvec. mret redirects fetch to the captured mepc.
// Ports:
//   clk, reset                  - clock, async active-low reset
//   except_valid, except_signal - E-stage valid and exception vector
//   pc_E, dm_addr_E, mret_E     - E-stage PC, data address, mret flag
//   mtvec                       - trap vector base (bits [1:0] ignored)
//   flush, stall_fetch          - pipeline squash and fetch hold
//   redirect, redirect_pc       - one-cycle fetch redirect and its target
//   mepc, mcause, mtval         - captured trap CSR values
//   trap_busy                   - sequence in progress, inputs ignored
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned N            = 64,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         except_valid,
    input  logic [6:0]   except_signal,
    input  logic [N-1:0] pc_E,
    input  logic [N-1:0] dm_addr_E,
    input  logic         mret_E,
    input  logic [N-1:0] mtvec,
    output logic         flush,
    output logic         stall_fetch,
    output logic         redirect,
    output logic [N-1:0] redirect_pc,
    output logic [N-1:0] mepc,
    output logic [N-1:0] mcause,
    output logic [N-1:0] mtval,
    output logic         trap_busy
);

    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(FLUSH_CYCLES - 1);

    trap_state_e  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  mepc_q, mcause_q, mtval_q;
    logic          capture;

    logic       enc_any;
    logic [3:0] enc_cause;
    logic       enc_use_pc;
    logic       trap_req;
    logic       mret_req;

    trap_prio_enc u_prio_enc (
        .vec    (except_signal),
        .any    (enc_any),
        .cause  (enc_cause),
        .use_pc (enc_use_pc)
    );

    assign trap_req = except_valid & enc_any;
    assign mret_req = except_valid & mret_E & ~enc_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (capture) begin
                mepc_q   <= pc_E;
                mcause_q <= N'(enc_cause);
                mtval_q  <= enc_use_pc ? pc_E : dm_addr_E;
            end
        end
    end

    // Requests are only looked at in StIdle, so nothing nests or overwrites.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trap_req) begin
                    capture = 1'b1;
                    count_d = '0;
                    state_d = StFlush;
                end else if (mret_req) begin
                    state_d = StRet;
                end
            end
            StFlush: begin
                count_d = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: state_d = StIdle;
            StRet:      state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Moore decodes of the state register only.
    always_comb begin
        flush       = 1'b0;
        stall_fetch = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        trap_busy   = 1'b0;
        unique case (state_q)
            StIdle: ;
            StFlush: begin
                flush       = 1'b1;
                stall_fetch = 1'b1;
                trap_busy   = 1'b1;
            end
            StRedirect: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                // mtvec is taken live here, not at capture time
                redirect_pc = mtvec & {{(N-2){1'b1}}, 2'b00};
                trap_busy   = 1'b1;
            end
            StRet: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = mepc_q;
                trap_busy   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mepc   = mepc_q;
    assign mcause = mcause_q;
    assign mtval  = mtval_q;

endmodule
